// File: rtl/lr_car_detector_if.sv
// Signal bundle between the local-road loop sensor front end and the light controller.
// The master side drives the raw sensor and light state; the slave side is the detector.
interface lr_car_detector_if #(
    parameter int CNT_W = 4
);
    logic             sensor_raw;
    logic [2:0]       lr_light;
    logic             lr_has_car;
    logic [CNT_W-1:0] car_count;
    logic             arrival;
    logic             overflow;

    modport master (
        output sensor_raw,
        output lr_light,
        input  lr_has_car,
        input  car_count,
        input  arrival,
        input  overflow
    );

    modport slave (
        input  sensor_raw,
        input  lr_light,
        output lr_has_car,
        output car_count,
        output arrival,
        output overflow
    );
endinterface

// File: rtl/lr_car_detector.sv
// Local-road vehicle detector: synchronises and debounces the loop sensor, counts waiting
// cars and retires one car per PASS_CYCLES contiguous green cycles.
module lr_car_detector #(
    parameter int DEBOUNCE    = 4,
    parameter int CNT_W       = 4,
    parameter int PASS_CYCLES = 10
) (
    input  logic              clk,
    input  logic              rst,
    lr_car_detector_if.slave  bus
);
    localparam int DEB_W  = $clog2(DEBOUNCE) + 1;
    localparam int PASS_W = $clog2(PASS_CYCLES) + 1;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE - 1);
    localparam logic [PASS_W-1:0] PASS_LAST = PASS_W'(PASS_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic [1:0] {IDLE, ARMING, PRESENT, RELEASING} state_t;

    logic [1:0]        sync_q;
    logic              s2;
    state_t            state_q, state_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic              deb_last;
    logic              arrival_ev;
    logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
    logic              depart_ev;
    logic              green;
    logic [CNT_W-1:0]  car_count_q, car_count_d;
    logic              overflow_q, overflow_d;
    logic              has_car_q;
    logic              arrival_q;

    // Two-flop synchroniser; only the second stage is allowed to reach the FSM.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst)
                    sync_q[gi] <= 1'b0;
                else
                    sync_q[gi] <= (gi == 0) ? bus.sensor_raw : sync_q[gi-1];
            end
        end
    endgenerate

    assign s2       = sync_q[1];
    assign deb_last = (deb_cnt_q == DEB_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            deb_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        case (state_q)
            IDLE: begin
                if (s2) begin
                    state_d   = ARMING;
                    deb_cnt_d = '0;
                end
            end
            ARMING: begin
                if (!s2)
                    state_d = IDLE;
                else if (deb_last)
                    state_d = PRESENT;
                else
                    deb_cnt_d = deb_cnt_q + 1'b1;
            end
            PRESENT: begin
                if (!s2) begin
                    state_d   = RELEASING;
                    deb_cnt_d = '0;
                end
            end
            RELEASING: begin
                // A bounce back high while releasing is the same vehicle, not a new one.
                if (s2)
                    state_d = PRESENT;
                else if (deb_last)
                    state_d = IDLE;
                else
                    deb_cnt_d = deb_cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        arrival_ev = (state_q == ARMING) && s2 && deb_last;
    end

    // Non-one-hot light codes never equal 001, so they fall out as not-green.
    assign green = (bus.lr_light == 3'b001);

    always_comb begin
        pass_cnt_d = '0;
        depart_ev  = 1'b0;
        if (green && (car_count_q != '0)) begin
            if (pass_cnt_q == PASS_LAST)
                depart_ev = 1'b1;
            else
                pass_cnt_d = pass_cnt_q + 1'b1;
        end
    end

    always_comb begin
        car_count_d = car_count_q;
        overflow_d  = overflow_q;
        case ({arrival_ev, depart_ev})
            2'b10: begin
                if (car_count_q == CNT_MAX)
                    overflow_d = 1'b1;
                else
                    car_count_d = car_count_q + 1'b1;
            end
            2'b01: begin
                if (car_count_q != '0)
                    car_count_d = car_count_q - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt_q  <= '0;
            car_count_q <= '0;
            overflow_q  <= 1'b0;
            has_car_q   <= 1'b0;
            arrival_q   <= 1'b0;
        end else begin
            pass_cnt_q  <= pass_cnt_d;
            car_count_q <= car_count_d;
            overflow_q  <= overflow_d;
            has_car_q   <= (car_count_d != '0);
            arrival_q   <= arrival_ev;
        end
    end

    assign bus.lr_has_car = has_car_q;
    assign bus.car_count  = car_count_q;
    assign bus.arrival    = arrival_q;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_lr_car_detector.sv
// Scoreboard bench for lr_car_detector (DEBOUNCE=4, CNT_W=4, PASS_CYCLES=10): every tick
// queues the expected outputs and the sampled outputs; each test drains and compares them.
module tb_lr_car_detector;
    typedef struct packed {
        logic       arr;
        logic       has;
        logic       ovf;
        logic [3:0] cnt;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   m_cnt = 0;
    logic m_ovf = 1'b0;
    obs_t exp_q[$];
    obs_t obs_q[$];

    lr_car_detector_if #(.CNT_W(4)) bus ();

    lr_car_detector #(
        .DEBOUNCE    (4),
        .CNT_W       (4),
        .PASS_CYCLES (10)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic arr, input int cnt, input logic ovf);
        obs_t e;
        e.arr = arr;
        e.has = (cnt != 0);
        e.ovf = ovf;
        e.cnt = 4'(cnt);
        return e;
    endfunction

    // One clock edge; outputs are sampled 1 ns after it, well away from either edge.
    task automatic tick_push(input obs_t e);
        obs_t o;
        @(posedge clk);
        #1;
        o.arr = bus.arrival;
        o.has = bus.lr_has_car;
        o.ovf = bus.overflow;
        o.cnt = bus.car_count;
        exp_q.push_back(e);
        obs_q.push_back(o);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.sensor_raw = 1'b0;
        bus.lr_light = 3'b100;
        m_cnt = 0;
        m_ovf = 1'b0;
        tick_push(mk(1'b0, 0, 1'b0));
        tick_push(mk(1'b0, 0, 1'b0));
        rst = 1'b0;
    endtask

    // Raw sensor high for hi ticks then low for lo ticks, light not green. The first edge
    // sampling raw high is tick 1, so an accepted arrival shows at tick 7 (k+DEBOUNCE+2).
    task automatic drive_car(input int hi, input int lo);
        logic a;
        for (int t = 1; t <= hi + lo; t++) begin
            bus.sensor_raw = (t <= hi);
            a = (t == 7) && (hi >= 5);
            if (a) begin
                if (m_cnt == 15) m_ovf = 1'b1;
                else             m_cnt++;
            end
            tick_push(mk(a, m_cnt, m_ovf));
        end
    endtask

    task automatic test_reset();
        obs_t e, o;
        int idx = 0;
        rst = 1'b1;
        do_reset();
        for (int t = 0; t < 3; t++) tick_push(mk(1'b0, 0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset#%0d got arr=%b has=%b ovf=%b cnt=%0d want arr=%b has=%b ovf=%b cnt=%0d",
                         idx, o.arr, o.has, o.ovf, o.cnt, e.arr, e.has, e.ovf, e.cnt);
            end
            idx++;
        end
        $display("test_reset done, %0d samples", idx);
    endtask

    task automatic test_first_arrival();
        obs_t e, o;
        int idx = 0;
        do_reset();
        bus.sensor_raw = 1'b1;
        for (int t = 1; t <= 9; t++) tick_push(mk(t == 7, (t >= 7) ? 1 : 0, 1'b0));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL first_arrival#%0d got arr=%b has=%b ovf=%b cnt=%0d want arr=%b has=%b ovf=%b cnt=%0d",
                         idx, o.arr, o.has, o.ovf, o.cnt, e.arr, e.has, e.ovf, e.cnt);
            end
            idx++;
        end
        $display("test_first_arrival done, %0d samples", idx);
    endtask

    task automatic test_glitch();
        obs_t e, o;
        int idx = 0;
        do_reset();
        for (int w = 1; w <= 3; w++) drive_car(w, 8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL glitch#%0d got arr=%b has=%b ovf=%b cnt=%0d want arr=%b has=%b ovf=%b cnt=%0d",
                         idx, o.arr, o.has, o.ovf, o.cnt, e.arr, e.has, e.ovf, e.cnt);
            end
            idx++;
        end
        $display("test_glitch done, %0d samples", idx);
    endtask

    task automatic test_departures();
        obs_t e, o;
        int idx = 0;
        do_reset();
        for (int i = 0; i < 3; i++) drive_car(8, 8);
        bus.lr_light = 3'b001;
        for (int j = 1; j <= 32; j++) tick_push(mk(1'b0, (j >= 30) ? 0 : 3 - j / 10, 1'b0));
        bus.lr_light = 3'b100;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL departures#%0d got arr=%b has=%b ovf=%b cnt=%0d want arr=%b has=%b ovf=%b cnt=%0d",
                         idx, o.arr, o.has, o.ovf, o.cnt, e.arr, e.has, e.ovf, e.cnt);
            end
            idx++;
        end
        $display("test_departures done, %0d samples", idx);
    endtask

    task automatic test_green_interrupt();
        obs_t e, o;
        int idx = 0;
        do_reset();
        drive_car(8, 8);
        bus.lr_light = 3'b001;
        for (int j = 0; j < 7; j++) tick_push(mk(1'b0, 1, 1'b0));
        bus.lr_light = 3'b010;
        for (int j = 0; j < 3; j++) tick_push(mk(1'b0, 1, 1'b0));
        bus.lr_light = 3'b011;
        tick_push(mk(1'b0, 1, 1'b0));
        bus.lr_light = 3'b001;
        for (int j = 1; j <= 11; j++) tick_push(mk(1'b0, (j >= 10) ? 0 : 1, 1'b0));
        bus.lr_light = 3'b100;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL green_interrupt#%0d got arr=%b has=%b ovf=%b cnt=%0d want arr=%b has=%b ovf=%b cnt=%0d",
                         idx, o.arr, o.has, o.ovf, o.cnt, e.arr, e.has, e.ovf, e.cnt);
            end
            idx++;
        end
        $display("test_green_interrupt done, %0d samples", idx);
    endtask

    task automatic test_saturation();
        obs_t e, o;
        int idx = 0;
        do_reset();
        for (int i = 0; i < 16; i++) drive_car(8, 8);
        for (int j = 0; j < 4; j++) tick_push(mk(1'b0, 15, 1'b1));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL saturation#%0d got arr=%b has=%b ovf=%b cnt=%0d want arr=%b has=%b ovf=%b cnt=%0d",
                         idx, o.arr, o.has, o.ovf, o.cnt, e.arr, e.has, e.ovf, e.cnt);
            end
            idx++;
        end
        $display("test_saturation done, %0d samples", idx);
    endtask

    // Raw goes high before green tick 4, so the arrival lands on green tick 10, the same
    // edge as the departure; then reset is applied with five cars still waiting.
    task automatic test_back_to_back();
        obs_t e, o;
        int idx = 0;
        do_reset();
        for (int i = 0; i < 5; i++) drive_car(8, 8);
        bus.lr_light = 3'b001;
        for (int j = 1; j <= 12; j++) begin
            if (j == 4) bus.sensor_raw = 1'b1;
            tick_push(mk(j == 10, 5, 1'b0));
        end
        rst = 1'b1;
        bus.sensor_raw = 1'b0;
        tick_push(mk(1'b0, 0, 1'b0));
        rst = 1'b0;
        for (int j = 0; j < 3; j++) tick_push(mk(1'b0, 0, 1'b0));
        bus.lr_light = 3'b100;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL back_to_back#%0d got arr=%b has=%b ovf=%b cnt=%0d want arr=%b has=%b ovf=%b cnt=%0d",
                         idx, o.arr, o.has, o.ovf, o.cnt, e.arr, e.has, e.ovf, e.cnt);
            end
            idx++;
        end
        $display("test_back_to_back done, %0d samples", idx);
    endtask

    initial begin
        bus.sensor_raw = 1'b0;
        bus.lr_light = 3'b100;
        test_reset();
        test_first_arrival();
        test_glitch();
        test_departures();
        test_green_interrupt();
        test_saturation();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
